mem_arbiter: RTL and testbench

- Shares one unified memory port between instruction fetch (imem) and the data memory stage (dmem).
- Both requesters use the single-cycle pulse protocol: a non-zero mask is held for exactly one cycle, then the requester waits for resp. The arbiter therefore captures each request into a pending buffer.
- It issues one downstream transaction at a time and routes the response back to its owner.
- Sits between the CPU pipeline (fetch and mem stages) and the cache/bus adapter.

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arb_req_buf.sv | 40 ++++
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified memory-port arbiter: FSM state and the
// request record held in each pending buffer.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        I_WAIT,
        D_WAIT
    } arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } mem_req_t;

    function automatic logic req_valid(input mem_req_t r);
        return |{r.rmask, r.wmask};
    endfunction

endpackage

// File: rtl/mem_arb_req_buf.sv
// One pending slot: captures a single-cycle request pulse and holds it
// until the arbiter reports the owning transaction complete.
module mem_arb_req_buf
    import mem_arbiter_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  mem_req_t in_req,
    input  logic     clear,
    output logic     pending,
    output logic     cap,
    output mem_req_t req
);

    mem_req_t req_q;
    logic     in_vld;

    assign in_vld = req_valid(in_req);
    // A request on the completing edge refills the slot; otherwise only an empty slot accepts.
    assign cap    = in_vld && (!pending || clear);
    assign req    = cap ? in_req : req_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            req_q   <= '0;
        end else if (cap) begin
            pending <= 1'b1;
            req_q   <= in_req;
        end else if (clear) begin
            pending <= 1'b0;
        end
    end

`ifndef SYNTHESIS
    a_no_overrun: assert property (@(posedge clk) disable iff (!rst_n)
        !(in_vld && pending && !clear));
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one downstream memory port between fetch (imem) and data (dmem).
// Define MEM_ARB_PERF_EN to build the grant/conflict performance counters.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      imem_addr,
    input  logic [3:0]       imem_rmask,
    output logic [31:0]      imem_rdata,
    output logic             imem_resp,
    input  logic [31:0]      dmem_addr,
    input  logic [3:0]       dmem_rmask,
    input  logic [3:0]       dmem_wmask,
    input  logic [31:0]      dmem_wdata,
    output logic [31:0]      dmem_rdata,
    output logic             dmem_resp,
    output logic [31:0]      mem_addr,
    output logic [3:0]       mem_rmask,
    output logic [3:0]       mem_wmask,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_resp,
    output logic [CNT_W-1:0] perf_imem_grants,
    output logic [CNT_W-1:0] perf_dmem_grants,
    output logic [CNT_W-1:0] perf_conflict_cycles
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    arb_state_t    state, state_d;
    logic [SW-1:0] starve_cnt, starve_d;
    mem_req_t      i_in, d_in, i_req, d_req, gnt_req;
    logic          i_pend, d_pend, i_cap, d_cap, i_clr, d_clr;
    logic          gnt_i, gnt_d, starved;

    always_comb begin
        i_in       = '0;
        i_in.addr  = imem_addr;
        i_in.rmask = imem_rmask;
        d_in       = '0;
        d_in.addr  = dmem_addr;
        d_in.wmask = dmem_wmask;
        d_in.wdata = dmem_wdata;
        // A combined load/store pulse is treated as the store alone.
        d_in.rmask = (dmem_wmask != '0) ? '0 : dmem_rmask;
    end

    assign i_clr = mem_resp && (state == I_WAIT);
    assign d_clr = mem_resp && (state == D_WAIT);

    mem_arb_req_buf u_ibuf (
        .clk(clk), .rst_n(rst_n), .in_req(i_in), .clear(i_clr),
        .pending(i_pend), .cap(i_cap), .req(i_req)
    );

    mem_arb_req_buf u_dbuf (
        .clk(clk), .rst_n(rst_n), .in_req(d_in), .clear(d_clr),
        .pending(d_pend), .cap(d_cap), .req(d_req)
    );

    assign imem_resp  = i_clr;
    assign dmem_resp  = d_clr;
    assign imem_rdata = mem_rdata;
    assign dmem_rdata = mem_rdata;
    assign starved    = (starve_cnt == SW'(STARVE_LIMIT));

    // On a completion the other port is handed the bus directly; if the owner
    // re-requested on that same edge the two compete under the starvation rule.
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        unique case (state)
            IDLE: begin
                if (d_pend && !(i_pend && starved)) gnt_d = 1'b1;
                else if (i_pend)                    gnt_i = 1'b1;
            end
            I_WAIT: begin
                if (mem_resp && (d_pend || d_cap)) begin
                    if (i_cap && starved) gnt_i = 1'b1;
                    else                  gnt_d = 1'b1;
                end
            end
            D_WAIT: begin
                if (mem_resp && (i_pend || i_cap)) begin
                    if (d_cap && !starved) gnt_d = 1'b1;
                    else                   gnt_i = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state;
        if (gnt_i)                           state_d = I_WAIT;
        else if (gnt_d)                      state_d = D_WAIT;
        else if (mem_resp && state != IDLE)  state_d = IDLE;

        if (gnt_i || !i_pend)                starve_d = '0;
        else if (gnt_d && !starved)          starve_d = starve_cnt + SW'(1);
        else                                 starve_d = starve_cnt;

        gnt_req = gnt_i ? i_req : d_req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= '0;
            mem_addr   <= '0;
            mem_rmask  <= '0;
            mem_wmask  <= '0;
            mem_wdata  <= '0;
        end else begin
            state      <= state_d;
            starve_cnt <= starve_d;
            mem_rmask  <= '0;
            mem_wmask  <= '0;
            if (gnt_i || gnt_d) begin
                mem_addr  <= gnt_req.addr;
                mem_rmask <= gnt_req.rmask;
                mem_wmask <= gnt_req.wmask;
                mem_wdata <= gnt_req.wdata;
            end
        end
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_imem_grants     <= '0;
            perf_dmem_grants     <= '0;
            perf_conflict_cycles <= '0;
        end else begin
            if (gnt_i) perf_imem_grants <= perf_imem_grants + CNT_W'(1);
            if (gnt_d) perf_dmem_grants <= perf_dmem_grants + CNT_W'(1);
            if (i_pend && d_pend && state != IDLE)
                perf_conflict_cycles <= perf_conflict_cycles + CNT_W'(1);
        end
    end
`else
    assign perf_imem_grants     = '0;
    assign perf_dmem_grants     = '0;
    assign perf_conflict_cycles = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a transaction-level model.
module tb_mem_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr = '0, dmem_addr = '0, dmem_wdata = '0, mem_rdata = '0;
    logic [3:0]  imem_rmask = '0, dmem_rmask = '0, dmem_wmask = '0;
    logic        mem_resp = 1'b0;
    logic [31:0] imem_rdata, dmem_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_rmask, mem_wmask;
    logic        imem_resp, dmem_resp;
    logic [31:0] perf_imem_grants, perf_dmem_grants, perf_conflict_cycles;

    int tests = 0;
    int fails = 0;

    mem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_rmask(imem_rmask),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .perf_imem_grants(perf_imem_grants), .perf_dmem_grants(perf_dmem_grants),
        .perf_conflict_cycles(perf_conflict_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_owner;   // 0 = bus free, 1 = imem transaction, 2 = dmem transaction
    bit          m_ipend, m_dpend;
    logic [31:0] m_iaddr, m_daddr, m_dwdata;
    logic [3:0]  m_irmask, m_drmask, m_dwmask;
    int          m_starve;
    logic [31:0] e_addr, e_wdata, e_pi, e_pd, e_pc;
    logic [3:0]  e_rmask, e_wmask;

    task automatic model_reset();
        m_owner = 0; m_ipend = 0; m_dpend = 0; m_starve = 0;
        m_iaddr = '0; m_daddr = '0; m_dwdata = '0;
        m_irmask = '0; m_drmask = '0; m_dwmask = '0;
        e_addr = '0; e_wdata = '0; e_rmask = '0; e_wmask = '0;
        e_pi = '0; e_pd = '0; e_pc = '0;
    endtask

    function automatic int pick_both();
        return (m_starve == LIMIT) ? 1 : 2;
    endfunction

    task automatic model_step();
        bit i_new, d_new, own_new, other_av;
        int g;
        i_new = (imem_rmask != 0);
        d_new = ((dmem_rmask | dmem_wmask) != 0);
        g = 0;
        if (m_owner == 0) begin
            if (m_ipend && m_dpend) g = pick_both();
            else if (m_dpend)       g = 2;
            else if (m_ipend)       g = 1;
        end else if (mem_resp) begin
            own_new  = (m_owner == 1) ? i_new : d_new;
            other_av = (m_owner == 1) ? (m_dpend || d_new) : (m_ipend || i_new);
            if (other_av) g = own_new ? pick_both() : 3 - m_owner;
        end
        if (m_ipend && m_dpend && m_owner != 0) e_pc = e_pc + 1;
        if (g == 1) e_pi = e_pi + 1;
        if (g == 2) e_pd = e_pd + 1;
        if (g == 1 || !m_ipend)            m_starve = 0;
        else if (g == 2 && m_starve < LIMIT) m_starve++;
        if (mem_resp && m_owner == 1) m_ipend = 0;
        if (mem_resp && m_owner == 2) m_dpend = 0;
        if (i_new && !m_ipend) begin
            m_ipend = 1; m_iaddr = imem_addr; m_irmask = imem_rmask;
        end
        if (d_new && !m_dpend) begin
            m_dpend = 1; m_daddr = dmem_addr; m_dwmask = dmem_wmask; m_dwdata = dmem_wdata;
            m_drmask = (dmem_wmask != 0) ? 4'h0 : dmem_rmask;
        end
        e_rmask = '0; e_wmask = '0;
        if (g == 1) begin
            e_addr = m_iaddr; e_rmask = m_irmask; e_wdata = '0; m_owner = 1;
        end else if (g == 2) begin
            e_addr = m_daddr; e_rmask = m_drmask; e_wmask = m_dwmask; e_wdata = m_dwdata; m_owner = 2;
        end else if (mem_resp) begin
            m_owner = 0;
        end
    endtask

    initial begin : model_proc
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    initial begin : compare_proc
        forever begin
            @(negedge clk);
            #2;
            chk("mem_addr",   mem_addr,        e_addr);
            chk("mem_rmask",  32'(mem_rmask),  32'(e_rmask));
            chk("mem_wmask",  32'(mem_wmask),  32'(e_wmask));
            chk("mem_wdata",  mem_wdata,       e_wdata);
            chk("imem_resp",  32'(imem_resp),  32'(mem_resp && m_owner == 1));
            chk("dmem_resp",  32'(dmem_resp),  32'(mem_resp && m_owner == 2));
            chk("imem_rdata", imem_rdata,      mem_rdata);
            chk("dmem_rdata", dmem_rdata,      mem_rdata);
`ifdef MEM_ARB_PERF_EN
            chk("perf_imem",     perf_imem_grants,     e_pi);
            chk("perf_dmem",     perf_dmem_grants,     e_pd);
            chk("perf_conflict", perf_conflict_cycles, e_pc);
`else
            chk("perf_imem_off", perf_imem_grants | perf_dmem_grants | perf_conflict_cycles, 32'h0);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic nxt();
        @(negedge clk);
        imem_rmask = '0; dmem_rmask = '0; dmem_wmask = '0;
        mem_resp = 1'b0; mem_rdata = $urandom;
    endtask

    initial begin : watchdog
        #1_000_000;
        tests++; fails++;
        $display("FAIL watchdog: simulation time budget expired");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : driver
        int grants, ipos, tmr, d_issued;
        bit last_d;

        repeat (3) @(negedge clk);
        #3;
        chk("rst_mem_rmask", 32'(mem_rmask), 32'h0);
        chk("rst_mem_wmask", 32'(mem_wmask), 32'h0);
        chk("rst_mem_addr",  mem_addr,       32'h0);
        chk("rst_perf",      perf_imem_grants | perf_dmem_grants | perf_conflict_cycles, 32'h0);
        nxt(); rst_n = 1'b1;

        // single load: pulse at T+2, response routed the same cycle as mem_resp
        nxt(); dmem_addr = 32'h100; dmem_rmask = 4'h1;
        nxt();
        nxt(); #3; chk("t1_rmask", 32'(mem_rmask), 32'h1); chk("t1_addr", mem_addr, 32'h100);
        nxt(); #3; chk("t1_pulse_end", 32'(mem_rmask), 32'h0);
        nxt();
        nxt(); mem_resp = 1'b1; mem_rdata = 32'hDEADBEEF;
        #3; chk("t1_dresp", 32'(dmem_resp), 32'h1); chk("t1_drdata", dmem_rdata, 32'hDEADBEEF);
        chk("t1_iresp", 32'(imem_resp), 32'h0);

        // same-cycle conflict: store first, fetch handed over with no bubble
        nxt(); imem_addr = 32'h0; imem_rmask = 4'hF;
        dmem_addr = 32'h200; dmem_wmask = 4'hF; dmem_wdata = 32'h12345678;
        nxt();
        nxt(); #3; chk("t2_wmask", 32'(mem_wmask), 32'hF); chk("t2_rmask0", 32'(mem_rmask), 32'h0);
        chk("t2_wdata", mem_wdata, 32'h12345678); chk("t2_addr", mem_addr, 32'h200);
        nxt(); mem_resp = 1'b1; #3; chk("t2_dresp", 32'(dmem_resp), 32'h1);
        nxt(); #3; chk("t2_no_bubble", 32'(mem_rmask), 32'hF); chk("t2_iaddr", mem_addr, 32'h0);
        nxt(); mem_resp = 1'b1; #3; chk("t2_iresp", 32'(imem_resp), 32'h1);

        // starvation: fetch pending while dmem re-requests on each completion
        nxt(); imem_addr = 32'h40; imem_rmask = 4'hF; dmem_addr = 32'h1000; dmem_rmask = 4'hF;
        d_issued = 1; grants = 0; ipos = -1; tmr = 0; last_d = 1'b0;
        for (int c = 0; c < 200; c++) begin
            nxt();
            if (tmr > 0) begin
                tmr--;
                if (tmr == 0) begin
                    mem_resp = 1'b1;
                    if (last_d && d_issued < 6) begin
                        dmem_addr = 32'h1000 + 32'(4 * d_issued); dmem_rmask = 4'hF; d_issued++;
                    end
                end
            end
            #1;
            if (mem_rmask != 0) begin
                last_d = (mem_addr != 32'h40);
                if (!last_d) ipos = grants;
                grants++;
                tmr = 2;
            end
            if (grants == 7 && tmr == 0) break;
        end
        chk("t3_imem_pos", 32'(ipos), 32'd4);
        chk("t3_grants",   32'(grants), 32'd7);

        // reset mid-transaction, then a late response
        nxt(); dmem_addr = 32'h500; dmem_rmask = 4'hF;
        nxt(); nxt();
        nxt(); rst_n = 1'b0;
        nxt(); nxt(); rst_n = 1'b1;
        nxt(); mem_resp = 1'b1; #3;
        chk("t4_dresp", 32'(dmem_resp), 32'h0); chk("t4_iresp", 32'(imem_resp), 32'h0);
        nxt(); #3; chk("t4_masks", 32'({mem_rmask, mem_wmask}), 32'h0);
        nxt(); imem_addr = 32'h80; imem_rmask = 4'hF;
        nxt();
        nxt(); #3; chk("t4_idle_grant", 32'(mem_rmask), 32'hF); chk("t4_addr", mem_addr, 32'h80);
        nxt(); mem_resp = 1'b1;

        // load+store on one pulse keeps only the store
        nxt(); dmem_addr = 32'h300; dmem_rmask = 4'hF; dmem_wmask = 4'h3; dmem_wdata = 32'hA5A5A5A5;
        nxt();
        nxt(); #3; chk("t5_wmask", 32'(mem_wmask), 32'h3); chk("t5_rmask", 32'(mem_rmask), 32'h0);
        chk("t5_wdata", mem_wdata, 32'hA5A5A5A5);
        nxt(); mem_resp = 1'b1; #3; chk("t5_dresp", 32'(dmem_resp), 32'h1);

        // perf: 3 fetches and 2 loads after a fresh reset
        nxt(); rst_n = 1'b0;
        nxt(); rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            nxt();
            if (k < 3) begin imem_addr = 32'(k * 4); imem_rmask = 4'hF; end
            else begin dmem_addr = 32'(32'h800 + k * 4); dmem_rmask = 4'h1; end
            nxt(); nxt();
            nxt(); mem_resp = 1'b1;
        end
        nxt(); #3;
`ifdef MEM_ARB_PERF_EN
        chk("t6_perf_i", perf_imem_grants, 32'd3);
        chk("t6_perf_d", perf_dmem_grants, 32'd2);
        chk("t6_perf_c", perf_conflict_cycles, 32'd0);
`else
        chk("t6_perf_i_off", perf_imem_grants, 32'd0);
        chk("t6_perf_d_off", perf_dmem_grants, 32'd0);
        chk("t6_perf_c_off", perf_conflict_cycles, 32'd0);
`endif

        // randomized traffic with a variable-latency responder
        tmr = 0;
        repeat (3000) begin
            nxt();
            if ((e_rmask | e_wmask) != 0) tmr = $urandom_range(1, 4);
            else if (tmr > 0) begin
                tmr--;
                if (tmr == 0) mem_resp = 1'b1;
            end else if (m_owner == 0 && $urandom_range(0, 15) == 0) mem_resp = 1'b1;
            if ((!m_ipend || (mem_resp && m_owner == 1)) && $urandom_range(0, 2) == 0) begin
                imem_rmask = 4'($urandom_range(1, 15));
                imem_addr  = $urandom & 32'hFFFF_FFFC;
            end
            if ((!m_dpend || (mem_resp && m_owner == 2)) && $urandom_range(0, 2) == 0) begin
                dmem_addr  = $urandom & 32'hFFFF_FFFC;
                dmem_wdata = $urandom;
                case ($urandom_range(0, 2))
                    0:       dmem_rmask = 4'($urandom_range(1, 15));
                    1:       dmem_wmask = 4'($urandom_range(1, 15));
                    default: begin
                        dmem_rmask = 4'($urandom_range(1, 15));
                        dmem_wmask = 4'($urandom_range(1, 15));
                    end
                endcase
            end
        end
        nxt(); nxt();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
